bcd_updown_counter_mux: RTL
===========================

Name: bcd_updown_counter_mux

Overview:
Parametrised successor of the single-button, single-digit counter. Three raw push-buttons (up, down, clear) are synchronised, debounced and edge-detected, then drive a DIGITS-wide BCD up/down counter. The counter is shown on a time-multiplexed common-anode 7-segment display, with optional leading-zero blanking. It sits at board top level between the raw pushbuttons and the display pins.

Parameters:
DIGITS, 4, number of BCD digits and display anodes (1..8)
DEB_CYCLES, 16, consecutive stable cycles required to accept a button level change (>=2)
SCAN_DIV, 1024, clock cycles per digit in the display scan (>=2)
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
btn_up  in  1  raw button, active-high, asynchronous to clk
btn_down  in  1  raw button, active-high, asynchronous to clk
btn_clr  in  1  raw button, active-high, asynchronous to clk
count_bcd  out  4*DIGITS  counter value; digit i at bits [4i+3:4i], digit 0 = least significant
wrap  out  1  one-cycle pulse when the counter wraps in either direction
seg  out  7  segments, active-low, seg[0]=a ... seg[6]=g
an  out  DIGITS  digit enables, active-low, one-hot-low

Behaviour:
- Reset (rst=0 at a clock edge) clears all registers: sync and debounce state 0, debounce counters 0, edge registers 0, count_bcd=0, wrap=0, scan divider=0, scan index=0. Consequently an = all ones except an[0]=0, and seg = 7'b1000000 ("0"). Reset mid-press: the button must be released and pressed again to count.
- Per-button path, all identical:
  - 2-FF synchroniser (s1, s2).
  - Debounce each cycle: if s2==deb, cnt<=0. Else if cnt==DEB_CYCLES-1, deb<=s2 and cnt<=0. Else cnt<=cnt+1.
  - A glitch shorter than DEB_CYCLES cycles never changes deb.
  - Rising-edge detector: p <= deb & ~deb_q; deb_q <= deb. Release produces no pulse. Holding the button gives exactly one pulse.
- Latency: the first edge sampling the new level is E0. deb flips at E(DEB_CYCLES+1), p is high after E(DEB_CYCLES+2), and count_bcd/wrap update at E(DEB_CYCLES+3).
- Counter, evaluated in priority order on the pulses:
  - clr pulse: count <= 0, wrap stays 0. Clear overrides up and down.
  - up and down pulses in the same cycle: no change.
  - up pulse: BCD increment with per-digit carry (9->0, carry to next digit). All-9s goes to 0 with wrap=1 for one cycle.
  - down pulse: BCD decrement with borrow (0->9). All-0s goes to all-9s with wrap=1 for one cycle.
  - Digits never hold values above 9.
- Scan: the divider counts 0..SCAN_DIV-1. On the cycle it equals SCAN_DIV-1, it returns to 0 and the index advances (DIGITS-1 wraps to 0). an[index]=0 and all other an bits are 1.
- seg decodes digit[index], active-low, bit order gfedcba:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blanking: with BLANK_LZ=1, a digit at index>0 that is 0 and has all higher digits 0 drives seg=1111111; its anode is still scanned.
- seg and an are combinational from the registered index and count. Both change in the same cycle, with no extra pipeline stage.

Test Plan:
(Bench parameters: DIGITS=2, DEB_CYCLES=4, SCAN_DIV=4, BLANK_LZ=1.)
- Reset: hold rst=0 for 2 cycles, then release -> count_bcd=8'h00, wrap=0, an=2'b10, seg=7'b1000000.
- Single up press: raise btn_up with E0 = the first sampling edge -> count_bcd=8'h01 after E7 (DEB_CYCLES+3); holding 50 cycles stays 8'h01; release gives no change.
- Bounce: btn_up toggles with high periods of 3 cycles, 10 times, then stays low -> count unchanged. Then a clean press -> +1.
- Wrap: preload to 8'h99 via presses, press up -> 8'h00 with wrap high exactly 1 cycle. Press down -> 8'h99 with wrap high 1 cycle. Press up from 8'h09 -> 8'h10.
- Simultaneous: up and down debounced on the same cycle -> count unchanged. clr together with up at 8'h42 -> 8'h00.
- Scan/blank: at count 8'h07 -> an alternates 10/01 every 4 cycles; seg=1111000 while an=10; seg=1111111 while an=01. At 8'h17, the digit-1 phase shows seg=1111001.

Source files
------------

// File: rtl/bcd_updown_counter_mux_if.sv
// Board-side signal bundle of the BCD up/down counter: raw buttons in, counter
// value and multiplexed 7-segment drive out.
interface bcd_updown_counter_mux_if #(
   parameter int DIGITS = 4
);
   logic                  btn_up;
   logic                  btn_down;
   logic                  btn_clr;
   logic [4*DIGITS-1:0]   count_bcd;
   logic                  wrap;
   logic [6:0]            seg;
   logic [DIGITS-1:0]     an;

   modport master (
      output btn_up, btn_down, btn_clr,
      input  count_bcd, wrap, seg, an
   );

   modport slave (
      input  btn_up, btn_down, btn_clr,
      output count_bcd, wrap, seg, an
   );
endinterface

// File: rtl/bcd_updown_counter_mux.sv
// Debounced three-button BCD up/down counter driving a time-multiplexed
// common-anode 7-segment display with optional leading-zero blanking.
module bcd_updown_counter_mux #(
   parameter int DIGITS     = 4,
   parameter int DEB_CYCLES = 16,
   parameter int SCAN_DIV   = 1024,
   parameter int BLANK_LZ   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   bcd_updown_counter_mux_if.slave bus
);
   localparam int CNT_W = $clog2(DEB_CYCLES);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int NBTN  = 3;
   localparam int B_UP   = 0;
   localparam int B_DOWN = 1;
   localparam int B_CLR  = 2;

   logic [NBTN-1:0]     w_btn_raw;
   logic [NBTN-1:0]     r_s1, r_s2, r_deb, r_deb_q, r_p;
   logic [CNT_W-1:0]    r_cnt [NBTN];

   logic [4*DIGITS-1:0] r_count, w_count_nxt, w_inc, w_dec;
   logic                r_wrap, w_wrap_nxt, w_inc_carry, w_dec_borrow;

   logic [DIV_W-1:0]    r_div;
   logic [IDX_W-1:0]    r_idx;
   logic [3:0]          w_digit;
   logic [DIGITS-1:0]   w_an;
   logic                w_upper_zero, w_blank;
   logic [6:0]          w_seg;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   assign w_btn_raw = {bus.btn_clr, bus.btn_down, bus.btn_up};

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_deb   <= '0;
         r_deb_q <= '0;
         r_p     <= '0;
         for (int b = 0; b < NBTN; b++) r_cnt[b] <= '0;
      end else begin
         r_s1    <= w_btn_raw;
         r_s2    <= r_s1;
         r_deb_q <= r_deb;
         r_p     <= r_deb & ~r_deb_q;
         for (int b = 0; b < NBTN; b++) begin
            if (r_s2[b] == r_deb[b]) begin
               r_cnt[b] <= '0;
            end else if (r_cnt[b] == CNT_W'(DEB_CYCLES - 1)) begin
               r_deb[b] <= r_s2[b];
               r_cnt[b] <= '0;
            end else begin
               r_cnt[b] <= r_cnt[b] + CNT_W'(1);
            end
         end
      end
   end

   // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_inc        = r_count;
      w_dec        = r_count;
      w_inc_carry  = 1'b1;
      w_dec_borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_inc_carry) begin
            if (r_count[4*i +: 4] == 4'd9) begin
               w_inc[4*i +: 4] = 4'd0;
            end else begin
               w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
               w_inc_carry     = 1'b0;
            end
         end
         if (w_dec_borrow) begin
            if (r_count[4*i +: 4] == 4'd0) begin
               w_dec[4*i +: 4] = 4'd9;
            end else begin
               w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
               w_dec_borrow    = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      w_wrap_nxt  = 1'b0;
      if (r_p[B_CLR]) begin
         w_count_nxt = '0;
      end else if (r_p[B_UP] && !r_p[B_DOWN]) begin
         w_count_nxt = w_inc;
         w_wrap_nxt  = w_inc_carry;
      end else if (r_p[B_DOWN] && !r_p[B_UP]) begin
         w_count_nxt = w_dec;
         w_wrap_nxt  = w_dec_borrow;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
         r_div   <= '0;
         r_idx   <= '0;
      end else begin
         r_count <= w_count_nxt;
         r_wrap  <= w_wrap_nxt;
         if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   // A digit is a leading zero when it and every digit above it are zero.
   always_comb begin
      w_digit      = 4'd0;
      w_an         = '1;
      w_upper_zero = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_digit = r_count[4*i +: 4];
            w_an[i] = 1'b0;
         end
         if ((IDX_W'(i) >= r_idx) && (r_count[4*i +: 4] != 4'd0)) w_upper_zero = 1'b0;
      end
      w_blank = (BLANK_LZ != 0) && (r_idx != '0) && w_upper_zero;
      w_seg   = w_blank ? 7'b1111111 : seg_decode(w_digit);
   end

   assign bus.count_bcd = r_count;
   assign bus.wrap      = r_wrap;
   assign bus.seg       = w_seg;
   assign bus.an        = w_an;
endmodule
